mmio_host_driver: RTL and testbench



---
 rtl/mmio_host_driver.sv | 210 +++++++++++++++++++++
 tb/tb_mmio_host_driver.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_host_driver.sv
// mmio_host_driver: serialises one host command into a burst of single-word
// MMIO writes (opcode, UB address, argument, optional MMVR payload, doorbell).
// It then polls the status register until DONE or timeout, and returns the
// last sampled status word on a valid/ready response channel.
`timescale 1ns/1ps

module mmio_host_driver #(
    parameter int HOST_DATA_WIDTH = 8,
    parameter int MMIO_ADDR_WIDTH = 8,
    parameter int ADDR_WIDTH      = 16,
    parameter int ARG_WIDTH       = 16,
    parameter int MMVR_WIDTH      = 64,
    parameter int REG_CMD         = 'h00,
    parameter int REG_ADDR        = 'h01,
    parameter int REG_ARG         = 'h04,
    parameter int REG_MMVR        = 'h08,
    parameter int REG_DOORBELL    = 'h40,
    parameter int REG_STATUS      = 'h41,
    parameter int DONE_BIT        = 1,
    parameter int POLL_SKIP       = 2,
    parameter int TIMEOUT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [HOST_DATA_WIDTH-1:0] req_cmd,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [ARG_WIDTH-1:0]       req_arg,
    input  logic [MMVR_WIDTH-1:0]      req_mmvr,
    input  logic                       req_has_mmvr,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [HOST_DATA_WIDTH-1:0] rsp_status,
    output logic                       rsp_timeout,
    input  logic [TIMEOUT_W-1:0]       timeout_limit,
    output logic [MMIO_ADDR_WIDTH-1:0] host_addr,
    output logic [HOST_DATA_WIDTH-1:0] host_wr_data,
    output logic                       host_wr_en,
    input  logic [HOST_DATA_WIDTH-1:0] host_rd_data
);

    localparam int HW    = HOST_DATA_WIDTH;
    localparam int AW    = (ADDR_WIDTH + HW - 1) / HW;
    localparam int GW    = (ARG_WIDTH + HW - 1) / HW;
    localparam int MW    = (MMVR_WIDTH + HW - 1) / HW;
    localparam int MAX1  = (AW > GW) ? AW : GW;
    localparam int MAX2  = (MAX1 > MW) ? MAX1 : MW;
    localparam int MAXC  = (MAX2 > POLL_SKIP + 1) ? MAX2 : POLL_SKIP + 1;
    localparam int CNT_W = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE, WR_CMD, WR_ADDR, WR_ARG, WR_MMVR, RING, POLL, RESP
    } state_t;

    state_t                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [TIMEOUT_W-1:0]       tcnt_q;
    logic [AW*HW-1:0]           addr_q;
    logic [GW*HW-1:0]           arg_q;
    logic [MW*HW-1:0]           mmvr_q;
    logic                       has_mmvr_q;
    logic                       req_ready_q;
    logic                       rsp_valid_q;
    logic [HW-1:0]              rsp_status_q;
    logic                       rsp_timeout_q;
    logic [MMIO_ADDR_WIDTH-1:0] host_addr_q;
    logic [HW-1:0]              host_wr_data_q;
    logic                       host_wr_en_q;

    // Index of the word that follows the one currently on the bus, and the
    // saturating sample count including the sample taken this cycle.
    logic [CNT_W-1:0]     cnt_inc;
    logic [TIMEOUT_W-1:0] tcnt_inc;
    logic                 done_seen;
    logic                 limit_hit;

    // Next-word and poll-termination helpers shared by the FSM below.
    always_comb begin
        cnt_inc   = cnt_q + 1'b1;
        tcnt_inc  = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
        done_seen = host_rd_data[DONE_BIT];
        limit_hit = (timeout_limit != '0) && (tcnt_inc >= timeout_limit);
    end

    // Command FSM; host outputs are registered for the state being entered,
    // so each state's word is on the bus for exactly the cycles it is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            tcnt_q         <= '0;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_status_q   <= '0;
            rsp_timeout_q  <= 1'b0;
            host_addr_q    <= '0;
            host_wr_data_q <= '0;
            host_wr_en_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q         <= (AW*HW)'(req_addr);
                        arg_q          <= (GW*HW)'(req_arg);
                        mmvr_q         <= (MW*HW)'(req_mmvr);
                        has_mmvr_q     <= req_has_mmvr;
                        req_ready_q    <= 1'b0;
                        state_q        <= WR_CMD;
                        cnt_q          <= '0;
                        host_addr_q    <= MMIO_ADDR_WIDTH'(REG_CMD);
                        host_wr_data_q <= req_cmd;
                        host_wr_en_q   <= 1'b1;
                    end
                end
                WR_CMD: begin
                    state_q        <= WR_ADDR;
                    cnt_q          <= '0;
                    host_addr_q    <= MMIO_ADDR_WIDTH'(REG_ADDR);
                    host_wr_data_q <= addr_q[0 +: HW];
                end
                WR_ADDR: begin
                    if (cnt_q == CNT_W'(AW - 1)) begin
                        state_q        <= WR_ARG;
                        cnt_q          <= '0;
                        host_addr_q    <= MMIO_ADDR_WIDTH'(REG_ARG);
                        host_wr_data_q <= arg_q[0 +: HW];
                    end else begin
                        cnt_q          <= cnt_inc;
                        host_addr_q    <= MMIO_ADDR_WIDTH'(REG_ADDR + int'(cnt_inc));
                        host_wr_data_q <= addr_q[int'(cnt_inc)*HW +: HW];
                    end
                end
                WR_ARG: begin
                    if (cnt_q == CNT_W'(GW - 1)) begin
                        cnt_q <= '0;
                        if (has_mmvr_q) begin
                            state_q        <= WR_MMVR;
                            host_addr_q    <= MMIO_ADDR_WIDTH'(REG_MMVR);
                            host_wr_data_q <= mmvr_q[0 +: HW];
                        end else begin
                            state_q        <= RING;
                            host_addr_q    <= MMIO_ADDR_WIDTH'(REG_DOORBELL);
                            host_wr_data_q <= HW'(1);
                        end
                    end else begin
                        cnt_q          <= cnt_inc;
                        host_addr_q    <= MMIO_ADDR_WIDTH'(REG_ARG + int'(cnt_inc));
                        host_wr_data_q <= arg_q[int'(cnt_inc)*HW +: HW];
                    end
                end
                WR_MMVR: begin
                    if (cnt_q == CNT_W'(MW - 1)) begin
                        state_q        <= RING;
                        cnt_q          <= '0;
                        host_addr_q    <= MMIO_ADDR_WIDTH'(REG_DOORBELL);
                        host_wr_data_q <= HW'(1);
                    end else begin
                        cnt_q          <= cnt_inc;
                        host_addr_q    <= MMIO_ADDR_WIDTH'(REG_MMVR + int'(cnt_inc));
                        host_wr_data_q <= mmvr_q[int'(cnt_inc)*HW +: HW];
                    end
                end
                RING: begin
                    // Doorbell is on the bus this cycle; next cycle starts polling.
                    state_q        <= POLL;
                    cnt_q          <= '0;
                    tcnt_q         <= '0;
                    host_addr_q    <= MMIO_ADDR_WIDTH'(REG_STATUS);
                    host_wr_data_q <= '0;
                    host_wr_en_q   <= 1'b0;
                end
                POLL: begin
                    // The word counter doubles as the skip counter so that the
                    // status just after the doorbell is never trusted.
                    if (cnt_q != CNT_W'(POLL_SKIP)) begin
                        cnt_q <= cnt_inc;
                    end else begin
                        rsp_status_q <= host_rd_data;
                        tcnt_q       <= tcnt_inc;
                        if (done_seen || limit_hit) begin
                            state_q       <= RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_timeout_q <= !done_seen;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q       <= IDLE;
                        rsp_valid_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        req_ready_q   <= 1'b1;
                        host_addr_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_status   = rsp_status_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign host_addr    = host_addr_q;
    assign host_wr_data = host_wr_data_q;
    assign host_wr_en   = host_wr_en_q;

endmodule

// File: tb/tb_mmio_host_driver.sv
// Bench for mmio_host_driver: a queue-based model of the expected write burst
// and poll/response behaviour, checked every cycle on the falling edge, plus
// hand-computed literal expectations for each directed scenario.
`timescale 1ns/1ps

module tb_mmio_host_driver;

    localparam int HW  = 8;
    localparam int MAW = 8;
    localparam int ADW = 16;
    localparam int ARW = 16;
    localparam int MVW = 64;
    localparam int TW  = 16;
    localparam int PSKIP = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [HW-1:0]  req_cmd = '0;
    logic [ADW-1:0] req_addr = '0;
    logic [ARW-1:0] req_arg = '0;
    logic [MVW-1:0] req_mmvr = '0;
    logic           req_has_mmvr = 1'b0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [HW-1:0]  rsp_status;
    logic           rsp_timeout;
    logic [TW-1:0]  timeout_limit = '0;
    logic [MAW-1:0] host_addr;
    logic [HW-1:0]  host_wr_data;
    logic           host_wr_en;
    logic [HW-1:0]  host_rd_data;

    mmio_host_driver #(
        .HOST_DATA_WIDTH(HW), .MMIO_ADDR_WIDTH(MAW), .ADDR_WIDTH(ADW),
        .ARG_WIDTH(ARW), .MMVR_WIDTH(MVW), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .req_arg(req_arg),
        .req_mmvr(req_mmvr), .req_has_mmvr(req_has_mmvr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
        .timeout_limit(timeout_limit),
        .host_addr(host_addr), .host_wr_data(host_wr_data),
        .host_wr_en(host_wr_en), .host_rd_data(host_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Status register model: base word, DONE from done_delay cycles after the
    // doorbell onwards, plus an optional single-cycle DONE pulse.
    logic [HW-1:0] stat_base = '0;
    int            done_delay = 0;
    int            pulse_at = 0;
    int            m_db_cyc = 0;
    bit            m_db_valid = 1'b0;
    logic [HW-1:0] st_word;

    always_comb begin
        st_word = stat_base;
        if (m_db_valid) begin
            if (done_delay != 0 && (cyc - m_db_cyc) >= done_delay) st_word[1] = 1'b1;
            if (pulse_at != 0 && (cyc - m_db_cyc) == pulse_at) st_word[1] = 1'b1;
        end
    end

    assign host_rd_data = (host_addr == 8'h41) ? st_word : 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    typedef enum {M_IDLE, M_WR, M_POLL, M_RESP} mphase_t;
    mphase_t     m_phase = M_IDLE;
    logic [15:0] exp_q[$];
    int          m_samples = 0;
    logic [HW-1:0] m_status = '0;
    bit          m_to = 1'b0;
    bit          cmp_en = 1'b0;

    int            ev_hs = 0, ev_db = 0, ev_rise = 0, ev_exit = 0;
    logic [HW-1:0] ev_status = '0;
    logic          ev_to = 1'b0;
    logic          prev_rv = 1'b0;
    logic [15:0]   wr_log[$];

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        logic [15:0] e;
        if (cmp_en) begin
            case (m_phase)
                M_IDLE: begin
                    chk("idle_req_ready", req_ready, 1);
                    chk("idle_rsp_valid", rsp_valid, 0);
                    chk("idle_wr_en", host_wr_en, 0);
                    if (req_valid) begin
                        exp_q.push_back({8'h00, req_cmd});
                        for (int k = 0; k < (ADW + HW - 1) / HW; k++)
                            exp_q.push_back({8'(8'h01 + k), req_addr[k*8 +: 8]});
                        for (int k = 0; k < (ARW + HW - 1) / HW; k++)
                            exp_q.push_back({8'(8'h04 + k), req_arg[k*8 +: 8]});
                        if (req_has_mmvr)
                            for (int k = 0; k < (MVW + HW - 1) / HW; k++)
                                exp_q.push_back({8'(8'h08 + k), req_mmvr[k*8 +: 8]});
                        exp_q.push_back(16'h4001);
                        m_db_valid = 1'b0;
                        m_phase = M_WR;
                    end
                end
                M_WR: begin
                    e = exp_q.pop_front();
                    chk("wr_en", host_wr_en, 1);
                    chk("wr_addr", host_addr, e[15:8]);
                    chk("wr_data", host_wr_data, e[7:0]);
                    chk("busy_req_ready", req_ready, 0);
                    chk("busy_rsp_valid", rsp_valid, 0);
                    if (exp_q.size() == 0) begin
                        m_phase = M_POLL;
                        m_db_cyc = cyc;
                        m_db_valid = 1'b1;
                        m_samples = 0;
                    end
                end
                M_POLL: begin
                    chk("poll_wr_en", host_wr_en, 0);
                    chk("poll_addr", host_addr, 8'h41);
                    chk("poll_rsp_valid", rsp_valid, 0);
                    chk("poll_req_ready", req_ready, 0);
                    if ((cyc - m_db_cyc) > PSKIP) begin
                        m_samples++;
                        if (st_word[1] || (timeout_limit != 0 && m_samples >= int'(timeout_limit))) begin
                            m_phase = M_RESP;
                            m_status = st_word;
                            m_to = !st_word[1];
                        end
                    end
                end
                M_RESP: begin
                    chk("resp_valid", rsp_valid, 1);
                    chk("resp_status", rsp_status, m_status);
                    chk("resp_timeout", rsp_timeout, m_to);
                    chk("resp_req_ready", req_ready, 0);
                    chk("resp_wr_en", host_wr_en, 0);
                    if (rsp_ready) m_phase = M_IDLE;
                end
                default: m_phase = M_IDLE;
            endcase
        end
        if (req_valid && req_ready) ev_hs = cyc;
        if (host_wr_en) wr_log.push_back({host_addr, host_wr_data});
        if (host_wr_en && host_addr == 8'h40) ev_db = cyc;
        if (rsp_valid === 1'b1 && prev_rv === 1'b0) begin
            ev_rise = cyc;
            ev_status = rsp_status;
            ev_to = rsp_timeout;
        end
        if (rsp_valid && rsp_ready) ev_exit = cyc;
        prev_rv = rsp_valid;
        if (rst) begin
            m_phase = M_IDLE;
            exp_q.delete();
            m_db_valid = 1'b0;
            cmp_en = 1'b1;
        end
    end

    task automatic send(input logic [7:0] c, input logic [15:0] a, input logic [15:0] g,
                        input logic [63:0] m, input bit h);
        int n;
        req_cmd = c; req_addr = a; req_arg = g; req_mmvr = m; req_has_mmvr = h;
        req_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 300);
        chk("handshake_wait", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int hold);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 300);
        chk("rsp_wait", rsp_valid, 1);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] t1_tab [6];

    initial begin
        t1_tab = '{16'h0003, 16'h0134, 16'h0212, 16'h0410, 16'h0500, 16'h4001};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_status", rsp_status, 0);
        chk("reset_rsp_timeout", rsp_timeout, 0);
        chk("reset_host_addr", host_addr, 0);
        chk("reset_wr_data", host_wr_data, 0);
        chk("reset_wr_en", host_wr_en, 0);
        @(posedge clk); #1;

        // T1: plain command, DONE 5 cycles after the doorbell.
        stat_base = 8'h00; done_delay = 5; pulse_at = 0; timeout_limit = 0;
        wr_log.delete();
        send(8'h03, 16'h1234, 16'h0010, 64'h0, 1'b0);
        wait_rsp(0);
        chk("t1_burst", ev_db - ev_hs, 6);
        chk("t1_log_size", wr_log.size(), 6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++)
            chk("t1_write", wr_log[i], t1_tab[i]);
        chk("t1_rise", ev_rise - ev_db, 6);
        chk("t1_status", ev_status, 8'h02);
        chk("t1_timeout", ev_to, 0);
        repeat (2) @(posedge clk); #1;

        // T2: with MMVR payload, 14-word burst.
        wr_log.delete();
        send(8'h03, 16'h1234, 16'h0010, 64'h8877665544332211, 1'b1);
        wait_rsp(0);
        chk("t2_burst", ev_db - ev_hs, 14);
        chk("t2_log_size", wr_log.size(), 14);
        for (int i = 0; i < 8 && (i + 5) < wr_log.size(); i++)
            chk("t2_mmvr", wr_log[i+5], {8'(8'h08 + i), 8'(17 * (i + 1))});
        if (wr_log.size() == 14) chk("t2_doorbell", wr_log[13], 16'h4001);
        repeat (2) @(posedge clk); #1;

        // T3: DONE pulse inside the skip window is ignored.
        done_delay = 7; pulse_at = 2;
        send(8'h21, 16'hBEEF, 16'h0102, 64'h0, 1'b0);
        wait_rsp(0);
        chk("t3_rise", ev_rise - ev_db, 8);
        chk("t3_status", ev_status, 8'h02);
        chk("t3_timeout", ev_to, 0);
        repeat (2) @(posedge clk); #1;

        // T4: timeout after exactly 4 evaluated samples.
        stat_base = 8'h05; done_delay = 0; pulse_at = 0; timeout_limit = 4;
        send(8'h44, 16'h0001, 16'hFFFF, 64'h0, 1'b0);
        wait_rsp(0);
        chk("t4_rise", ev_rise - ev_db, 7);
        chk("t4_status", ev_status, 8'h05);
        chk("t4_timeout", ev_to, 1);
        timeout_limit = 0; stat_base = 8'h00;
        repeat (2) @(posedge clk); #1;

        // T5: response held 10 cycles while a second request waits.
        done_delay = 5; rsp_ready = 1'b0;
        send(8'h55, 16'hA5A5, 16'h5A5A, 64'h0, 1'b0);
        fork
            send(8'h66, 16'h0F0F, 16'hF0F0, 64'h0123456789ABCDEF, 1'b1);
            wait_rsp(10);
        join
        chk("t5_accept", ev_hs - ev_exit, 1);
        wait_rsp(0);
        chk("t5b_status", ev_status, 8'h02);
        repeat (2) @(posedge clk); #1;

        // T6: reset pulsed while the argument word is on the bus.
        send(8'h77, 16'h4321, 16'h9876, 64'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_wr_en", host_wr_en, 0);
        chk("t6_req_ready", req_ready, 1);
        chk("t6_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        send(8'h88, 16'h1111, 16'h2222, 64'h0, 1'b0);
        wait_rsp(0);
        chk("t6_burst", ev_db - ev_hs, 6);
        chk("t6_status", ev_status, 8'h02);
        chk("t6_timeout", ev_to, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
